serial_compare_scheduler: RTL and testbench
===========================================

SERIAL_COMPARE_SCHEDULER -- requirements
Module: serial_compare_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have ports req_valid, input, 2 bits, one per requester: the operand pair is presented.
REQ-005 The block SHALL have ports req_a0, req_b0, req_a1, req_b1, input, WIDTH bits each: operands of requester 0 and requester 1.
REQ-006 The block SHALL have port req_ready, output, 2 bits: the per-requester accept strobe; a transfer occurs when req_valid[i] & req_ready[i].
REQ-007 The block SHALL have port resp_valid, output, 1 bit: the result is available.
REQ-008 The block SHALL have port resp_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port resp_id, output, 1 bit: the index of the requester that owns the result.
REQ-010 The block SHALL have ports a_less_b, a_eq_b, a_greater_b, output, 1 bit each: the one-hot compare result, valid while resp_valid is high.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and RESP.
REQ-013 In IDLE, the block SHALL drive req_ready high only for the granted requester: the priority holder if it is valid, otherwise the other requester if it is valid; otherwise req_ready SHALL be 0. req_ready SHALL be 0 outside IDLE.
REQ-014 On acceptance, the block SHALL latch both operands and resp_id, clear the core to EQUAL, load the bit counter with WIDTH-1, enter SHIFT, and pass priority to the other requester.
REQ-015 In SHIFT, the block SHALL feed one bit pair per cycle to the core, MSB first, indexed by the counter; after bit 0 it SHALL enter RESP.
REQ-016 Latency SHALL be fixed: resp_valid rises WIDTH+1 edges after the acceptance edge, with no early termination on a decided result.
REQ-017 Core rule: in EQUAL, a=0,b=1 moves to LESS and a=1,b=0 moves to GREATER; LESS and GREATER are sticky until the core is cleared.
REQ-018 In RESP, the result outputs SHALL be registered, exactly one SHALL be high, and they SHALL be held stable until resp_valid & resp_ready.
REQ-019 The handshake in REQ-018 SHALL return the block to IDLE; a new acceptance is possible on the following edge, never the same edge.
REQ-020 If only one requester is valid, it SHALL be granted regardless of priority, and priority SHALL still toggle away from it.
REQ-021 Requester operand changes outside the accept cycle SHALL have no effect on an in-flight compare.

Reset
REQ-022 While rst_n=0 at an edge, the block SHALL set state to IDLE, priority to requester 0, core to EQUAL and counter to 0, aborting any transaction in flight.
REQ-023 Reset values SHALL be: resp_valid=0, req_ready=0, busy=0, resp_id=0, a_eq_b=1, a_less_b=0, a_greater_b=0.

Structure
REQ-024 A shared package serial_compare_pkg SHALL hold the scheduler state enum, the core result enum (EQUAL, LESS, GREATER) and the requester-count constant (2).
REQ-025 The bit-serial MSB-first compare FSM SHALL be a sub-module, serial_compare_core, with ports clk, rst_n, clear, en, a, b, result; the scheduler owns arbitration, counter and response registers.

Verification (WIDTH=8)
REQ-026 The bench SHALL cover: req0 a=0x64, b=0x62 -> resp_valid 9 edges after accept, resp_id=0, a_greater_b=1.
REQ-027 The bench SHALL cover: req1 a=0xA5, b=0xA5 -> resp_id=1, a_eq_b=1.
REQ-028 The bench SHALL cover: req0 a=0x7F, b=0x80 -> a_less_b=1, with the core decided after the first SHIFT cycle.
REQ-029 The bench SHALL cover: both requesters valid continuously after reset -> grants in order 0,1,0,1, with resp_id matching each grant.
REQ-030 The bench SHALL cover: resp_ready held 0 for 3 cycles in RESP -> outputs stable, req_ready=0; then one cycle after the handshake, req_ready returns for the next requester.
REQ-031 The bench SHALL cover: rst_n=0 for one edge at SHIFT bit 4 -> next cycle busy=0, resp_valid=0, a_eq_b=1, and the next grant goes to requester 0.

Source files
------------

// File: rtl/serial_compare_pkg.sv
// Shared types for the serial compare scheduler: scheduler states, compare
// results and the requester count.
package serial_compare_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } sched_state_e;

  typedef enum logic [1:0] {
    EQUAL   = 2'd0,
    LESS    = 2'd1,
    GREATER = 2'd2
  } cmp_result_e;

  // Packed as {less, eq, greater} to match the response output ordering.
  function automatic logic [2:0] result_onehot(input cmp_result_e r);
    logic [2:0] oh;
    case (r)
      LESS:    oh = 3'b100;
      GREATER: oh = 3'b001;
      default: oh = 3'b010;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/serial_compare_scheduler_if.sv
// Request/response bundle between two requesters, one consumer and the
// serial compare scheduler.
interface serial_compare_scheduler_if #(
  parameter int WIDTH = 8
);
  import serial_compare_pkg::*;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [WIDTH-1:0]   req_a0;
  logic [WIDTH-1:0]   req_b0;
  logic [WIDTH-1:0]   req_a1;
  logic [WIDTH-1:0]   req_b1;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_id;
  logic               a_less_b;
  logic               a_eq_b;
  logic               a_greater_b;
  logic               busy;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
    input  req_ready, resp_valid, resp_id, a_less_b, a_eq_b, a_greater_b, busy
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
    output req_ready, resp_valid, resp_id, a_less_b, a_eq_b, a_greater_b, busy
  );

endinterface

// File: rtl/serial_compare_scheduler_core.sv
// Bit-serial magnitude comparator: consumes one bit pair per enabled cycle,
// MSB first, and remembers the first differing bit.
module serial_compare_core
  import serial_compare_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic        a,
  input  logic        b,
  output cmp_result_e result
);

  cmp_result_e result_q;
  cmp_result_e result_d;

  // Once a higher bit has decided the order, lower bits cannot change it.
  always_comb begin
    result_d = result_q;
    if (clear) begin
      result_d = EQUAL;
    end else if (en && (result_q == EQUAL)) begin
      if (!a && b) begin
        result_d = LESS;
      end else if (a && !b) begin
        result_d = GREATER;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= EQUAL;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/serial_compare_scheduler.sv
// Two-requester round-robin front end for the bit-serial comparator; owns
// arbitration, operand capture, the bit counter and the response registers.
module serial_compare_scheduler
  import serial_compare_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                       clk,
  input logic                       rst_n,
  serial_compare_scheduler_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  sched_state_e       state_q, state_d;
  logic               prio_q, prio_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_id_q, resp_id_d;
  logic [2:0]         result_q, result_d;
  logic [NUM_REQ-1:0] grant;
  logic               grant_id;
  logic               accept;
  logic               core_clear;
  logic               core_en;
  cmp_result_e        core_result;

  // The priority holder wins a tie; a lone valid requester always wins.
  always_comb begin
    grant = '0;
    if (prio_q) begin
      if (bus.req_valid[1]) begin
        grant = 2'b10;
      end else if (bus.req_valid[0]) begin
        grant = 2'b01;
      end
    end else begin
      if (bus.req_valid[0]) begin
        grant = 2'b01;
      end else if (bus.req_valid[1]) begin
        grant = 2'b10;
      end
    end
  end

  assign grant_id      = grant[1];
  assign accept        = (state_q == IDLE) && (grant != '0);
  assign bus.req_ready = (rst_n && (state_q == IDLE)) ? grant : '0;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    result_d     = result_q;
    core_clear   = 1'b0;
    core_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d     = grant_id ? bus.req_a1 : bus.req_a0;
          op_b_d     = grant_id ? bus.req_b1 : bus.req_b0;
          resp_id_d  = grant_id;
          prio_d     = ~grant_id;
          cnt_d      = CNT_LOAD;
          core_clear = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        core_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // First RESP cycle captures the settled core result into the outputs.
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          result_d     = result_onehot(core_result);
        end else if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      result_q     <= 3'b010;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      result_q     <= result_d;
    end
  end

  serial_compare_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (core_clear),
    .en     (core_en),
    .a      (op_a_q[cnt_q]),
    .b      (op_b_q[cnt_q]),
    .result (core_result)
  );

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.a_less_b    = result_q[2];
  assign bus.a_eq_b      = result_q[1];
  assign bus.a_greater_b = result_q[0];
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Self-checking bench for serial_compare_scheduler (WIDTH=8): directed table,
// hand-written corner sequences and randomized traffic against a simple model.
module tb_serial_compare_scheduler;
  import serial_compare_pkg::*;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       exp_id;
    logic [2:0] exp_res;
    int         hold;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic model_prio;
  vec_t vecs[9];

  serial_compare_scheduler_if #(.WIDTH(8)) bus ();

  serial_compare_scheduler #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 1'b0;
    step_clk();
    step_clk();
    rst_n      = 1'b1;
    model_prio = 1'b0;
  endtask

  // Order of the top k bits of each operand, from plain integer arithmetic.
  function automatic cmp_result_e prefix_cmp(input logic [7:0] a, input logic [7:0] b,
                                             input int k);
    int pa;
    int pb;
    pa = int'(a) >> (8 - k);
    pb = int'(b) >> (8 - k);
    if (pa < pb) return LESS;
    if (pa > pb) return GREATER;
    return EQUAL;
  endfunction

  task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] a0,
                               input logic [7:0] b0, input logic [7:0] a1,
                               input logic [7:0] b1, input logic exp_id,
                               input logic [2:0] exp_res, input int hold);
    logic [7:0] ea;
    logic [7:0] eb;
    int         lat;
    ea             = exp_id ? a1 : a0;
    eb             = exp_id ? b1 : b0;
    bus.req_valid  = valid;
    bus.req_a0     = a0;
    bus.req_b0     = b0;
    bus.req_a1     = a1;
    bus.req_b1     = b1;
    bus.resp_ready = 1'b0;
    #1;
    checkOutput("req_ready_grant", 32'(bus.req_ready), exp_id ? 32'h2 : 32'h1);
    step_clk();
    bus.req_a0 = 8'($urandom);
    bus.req_b0 = 8'($urandom);
    bus.req_a1 = 8'($urandom);
    bus.req_b1 = 8'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step_clk();
      if (k <= 8) checkOutput("core_prefix", 32'(dut.u_core.result), 32'(prefix_cmp(ea, eb, k)));
      if (k == 1) checkOutput("req_ready_busy", 32'(bus.req_ready), 32'h0);
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("latency", 32'(lat), 32'd9);
    checkOutput("resp_id", 32'(bus.resp_id), 32'(exp_id));
    checkOutput("result", 32'({bus.a_less_b, bus.a_eq_b, bus.a_greater_b}), 32'(exp_res));
    for (int h = 0; h < hold; h++) begin
      step_clk();
      checkOutput("hold_valid", 32'(bus.resp_valid), 32'h1);
      checkOutput("hold_result", 32'({bus.a_less_b, bus.a_eq_b, bus.a_greater_b}), 32'(exp_res));
      checkOutput("hold_req_ready", 32'(bus.req_ready), 32'h0);
    end
    bus.resp_ready = 1'b1;
    step_clk();
    bus.resp_ready = 1'b0;
    checkOutput("idle_busy", 32'(bus.busy), 32'h0);
    checkOutput("idle_resp_valid", 32'(bus.resp_valid), 32'h0);
  endtask

  initial begin
    logic [1:0] rv;
    logic [7:0] ra0, rb0, ra1, rb1, ea, eb;
    logic       g;
    logic [2:0] er;
    int         lat;

    tests          = 0;
    fails          = 0;
    model_prio     = 1'b0;
    rst_n          = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_a0     = '0;
    bus.req_b0     = '0;
    bus.req_a1     = '0;
    bus.req_b1     = '0;
    bus.resp_ready = 1'b0;

    vecs[0] = '{2'b01, 8'h64, 8'h62, 8'h00, 8'h00, 1'b0, R_GT, 0};
    vecs[1] = '{2'b10, 8'h00, 8'h00, 8'hA5, 8'hA5, 1'b1, R_EQ, 1};
    vecs[2] = '{2'b01, 8'h7F, 8'h80, 8'h00, 8'h00, 1'b0, R_LT, 0};
    vecs[3] = '{2'b11, 8'h10, 8'h20, 8'hFF, 8'h00, 1'b1, R_GT, 0};
    vecs[4] = '{2'b11, 8'h01, 8'h02, 8'h55, 8'h44, 1'b0, R_LT, 2};
    vecs[5] = '{2'b01, 8'h00, 8'h00, 8'h12, 8'h34, 1'b0, R_EQ, 0};
    vecs[6] = '{2'b11, 8'h80, 8'h7F, 8'h3C, 8'h3C, 1'b1, R_EQ, 0};
    vecs[7] = '{2'b10, 8'hAA, 8'hBB, 8'h00, 8'h01, 1'b1, R_LT, 3};
    vecs[8] = '{2'b11, 8'hC3, 8'hC4, 8'h99, 8'h11, 1'b0, R_LT, 0};

    step_clk();
    step_clk();
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_resp_id", 32'(bus.resp_id), 32'h0);
    checkOutput("rst_a_eq_b", 32'(bus.a_eq_b), 32'h1);
    checkOutput("rst_a_less_b", 32'(bus.a_less_b), 32'h0);
    checkOutput("rst_a_greater_b", 32'(bus.a_greater_b), 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_no_valid_ready", 32'(bus.req_ready), 32'h0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                    vecs[i].exp_id, vecs[i].exp_res, vecs[i].hold);
    end

    // Both requesters held valid with the consumer always ready: strict alternation.
    do_reset();
    bus.req_valid  = 2'b11;
    bus.req_a0     = 8'h11;
    bus.req_b0     = 8'h22;
    bus.req_a1     = 8'h33;
    bus.req_b1     = 8'h33;
    bus.resp_ready = 1'b1;
    #1;
    for (int t = 0; t < 4; t++) begin
      g = t[0];
      checkOutput("rr_grant", 32'(bus.req_ready), g ? 32'h2 : 32'h1);
      step_clk();
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
        step_clk();
        if (bus.resp_valid) begin
          lat = k;
          break;
        end
      end
      checkOutput("rr_latency", 32'(lat), 32'd9);
      checkOutput("rr_resp_id", 32'(bus.resp_id), 32'(g));
      checkOutput("rr_result", 32'({bus.a_less_b, bus.a_eq_b, bus.a_greater_b}),
                  g ? 32'(R_EQ) : 32'(R_LT));
      step_clk();
      checkOutput("rr_idle", 32'(bus.busy), 32'h0);
    end
    bus.resp_ready = 1'b0;

    // Reset while the counter points at bit 4 must abort and restore priority 0.
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_a0    = 8'hF0;
    bus.req_b0    = 8'h0F;
    #1;
    checkOutput("abort_grant", 32'(bus.req_ready), 32'h1);
    step_clk();
    step_clk();
    step_clk();
    step_clk();
    rst_n = 1'b0;
    step_clk();
    rst_n = 1'b1;
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    checkOutput("abort_resp_valid", 32'(bus.resp_valid), 32'h0);
    checkOutput("abort_a_eq_b", 32'(bus.a_eq_b), 32'h1);
    checkOutput("abort_core", 32'(dut.u_core.result), 32'(EQUAL));
    applyStimulus(2'b11, 8'h01, 8'h01, 8'hFE, 8'h02, 1'b0, R_EQ, 0);

    // Randomized traffic against the arbitration/compare model.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      rv  = 2'($urandom_range(1, 3));
      ra0 = 8'($urandom);
      rb0 = ($urandom_range(0, 3) == 0) ? ra0 : 8'($urandom);
      ra1 = 8'($urandom);
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : 8'($urandom);
      g   = rv[model_prio] ? model_prio : ~model_prio;
      ea  = g ? ra1 : ra0;
      eb  = g ? rb1 : rb0;
      er  = (ea < eb) ? R_LT : ((ea > eb) ? R_GT : R_EQ);
      model_prio = ~g;
      applyStimulus(rv, ra0, rb0, ra1, rb1, g, er, int'($urandom_range(0, 2)));
    end
    bus.req_valid = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
